// File: rtl/merge_2x1.sv
// -----------------------------------------------------------------------------
// merge_2x1
//
// Registered 2-to-1 stream merger with round-robin arbitration. Words from two
// producer channels are collected into a single output slot and tagged with
// their source index, which downstream logic uses as the select bit of a 1:2
// demultiplexer to route replies back to the right producer.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in0_valid  channel 0 word present
//   in0_data   channel 0 word
//   in0_ready  channel 0 word accepted when high together with in0_valid
//   in1_valid  channel 1 word present
//   in1_data   channel 1 word
//   in1_ready  channel 1 word accepted when high together with in1_valid
//   out_valid  output slot holds a word
//   out_data   merged word
//   out_src    source of out_data (0 = channel 0, 1 = channel 1)
//   out_ready  consumer accepts the output word when high with out_valid
// -----------------------------------------------------------------------------
module merge_2x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_src_q,   out_src_d;
    logic             last_grant_q, last_grant_d;

    logic load;
    logic grant0;
    logic grant1;

    // The slot can take a new word when it is empty or being drained now.
    assign load = !out_valid_q || out_ready;

    // Round-robin: a lone requester always wins; under contention the channel
    // that was not granted most recently wins.
    assign grant0 = in0_valid && (!in1_valid || last_grant_q);
    assign grant1 = in1_valid && (!in0_valid || !last_grant_q);

    // Readies are forced low during reset so no handshake completes while the
    // slot is being cleared.
    assign in0_ready = rst_n && load && grant0;
    assign in1_ready = rst_n && load && grant1;

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;

        if (in0_ready) begin
            out_valid_d  = 1'b1;
            out_data_d   = in0_data;
            out_src_d    = 1'b0;
            last_grant_d = 1'b0;
        end else if (in1_ready) begin
            out_valid_d  = 1'b1;
            out_data_d   = in1_data;
            out_src_d    = 1'b1;
            last_grant_d = 1'b1;
        end else if (load) begin
            // Drained (or already empty) with nothing to load: data and source
            // keep their last values, only the valid flag drops.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            // Reset to 1 so channel 0 wins the first contended cycle.
            last_grant_q <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: doc/merge_2x1.md
# merge_2x1

Registered 2-to-1 stream merger with round-robin arbitration. It collects words from two producer channels onto one consumer channel and tags each word with its source index. The tag is the select bit the downstream 1:2 demultiplexer uses to route replies back. The block sits between the two datapath producers and the shared bus.

## Interface
- `WIDTH`, default 8: data width of every channel.

- `clk`  input  1  rising-edge clock; all state updates on this edge.
- `rst_n`  input  1  reset; synchronous and active-low.
- `in0_valid`  input  1  channel 0 word present.
- `in0_data`  input  WIDTH  channel 0 word.
- `in0_ready`  output  1  channel 0 word accepted this cycle when high together with in0_valid.
- `in1_valid`  input  1  channel 1 word present.
- `in1_data`  input  WIDTH  channel 1 word.
- `in1_ready`  output  1  channel 1 word accepted this cycle when high together with in1_valid.
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  WIDTH  merged word.
- `out_src`  output  1  source of out_data: 0 = channel 0, 1 = channel 1.
- `out_ready`  input  1  consumer accepts the output word when high with out_valid.

## Operation
- State:
  - One output slot: out_valid, out_data, out_src.
  - One priority bit `last_grant`, which records the channel granted most recently.
- `load` = !out_valid || out_ready. The slot is empty or is being drained this cycle.
- Grant, combinational, evaluated only when load = 1:
  - Only in0_valid high: grant channel 0.
  - Only in1_valid high: grant channel 1.
  - Both high: grant !last_grant (round-robin).
  - Neither high: no grant.
- in0_ready = load && grant0, and in1_ready = load && grant1.
  - At most one ready is high per cycle.
  - A ready may be high while its valid is low only if the rule above gives that channel a grant. With no valid input, both readies are 0.
- On a transfer from channel k:
  - out_data <= ink_data, out_src <= k, out_valid <= 1, last_grant <= k.
- Drain without a new transfer (out_valid && out_ready, no grant): out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous drain and load in the same cycle: the new word replaces the old one, so back-to-back streaming runs at one word per cycle.
- out_valid && !out_ready:
  - Slot holds; both readies are 0.
  - out_data and out_src are stable until accepted.
- Producers must keep valid and data stable until ready. The block does not check this.
- last_grant changes only on an actual transfer.

## Timing
- Reset (rst_n = 0 at an edge): out_valid = 0, out_data = 0, out_src = 0, last_grant = 1.
  - With last_grant = 1, channel 0 wins the first contended cycle.
  - in0_ready and in1_ready are 0 while rst_n is low, regardless of load.
- Reset applied mid-transfer discards the held word. No handshake completes in a cycle where rst_n = 0.
- Latency: a word accepted at edge N appears on out_data with out_valid = 1 after edge N, and can be consumed in cycle N+1.
- Throughput:
  - One word per cycle when out_ready stays high.
  - Under continuous contention, channels alternate strictly: 0,1,0,1…
- in*_ready depends combinationally on out_ready, in*_valid and state. There is no combinational path from any data input to any output.

## Test plan
1. Reset release, no traffic:
   - Hold rst_n = 0 for 2 cycles, then release with both valids low.
   - Required: out_valid = 0, out_data = 0, out_src = 0, both readies 0.
2. Single channel streaming:
   - Apply in1_valid = 1 with data 0x11, 0x22, 0x33 on consecutive cycles, out_ready = 1.
   - Required: out_data 0x11, 0x22, 0x33 on the following cycles, out_src = 1, no bubbles.
3. Contention:
   - Apply both valids high for 4 cycles, ch0 = 0xA0… and ch1 = 0xB0…, out_ready = 1.
   - Required: output order ch0, ch1, ch0, ch1; out_src = 0, 1, 0, 1; each channel's ready high every other cycle.
4. Backpressure:
   - Load 0x5A, then hold out_ready = 0 for 3 cycles with in0_valid = 1 (data 0x6B).
   - Required: out_data = 0x5A stable, in0_ready = 0. When out_ready rises, 0x5A is consumed and 0x6B is loaded the same cycle.
5. Drain to empty:
   - Consume one word with no further valids.
   - Required: out_valid = 0 on the next cycle; last_grant unchanged by the idle cycles.
6. Reset mid-operation:
   - Assert rst_n = 0 while out_valid = 1 with data 0x77.
   - Required: out_valid = 0 and out_data = 0 next cycle; the first contended grant after release goes to channel 0.
